// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART blocks.
//   state_t  - receiver frame state machine encoding
//   parity_t - parity mode selector (none / even / odd)
//   maj3     - 2-of-3 majority vote used for oversampled bit decisions
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: oversampling tick generator.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - restart the count from 0 (used to align ticks to a start edge)
//   tick - one-cycle strobe every DIVISOR clocks (on the counter wrap)
module baud_tick_gen #(
    parameter int DIVISOR = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with majority voting, optional parity,
// 1 or 2 stop bits and a valid/ready frame interface.
//   clk        - system clock (single domain)
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial input, idles high
//   data_out   - received data word (LSB first on the line)
//   valid      - data_out and the error flags hold a frame
//   ready      - consumer accepts the held frame when valid && ready
//   parity_err - parity mismatch for the held frame (0 when parity is off)
//   frame_err  - a stop bit of the held frame was sampled 0
//   overrun    - one-cycle pulse: a completed frame was dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 250000,
    parameter int N_BITS     = 8,
    parameter int N_SAMPLES  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [N_BITS-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int DIVISOR = CLOCK_RATE / (BAUD_RATE * N_SAMPLES);
    localparam int TW      = $clog2(N_SAMPLES);
    localparam int BW      = $clog2(N_BITS + 1);

    localparam logic [TW-1:0] T_V0   = TW'(N_SAMPLES / 2 - 1);
    localparam logic [TW-1:0] T_V1   = TW'(N_SAMPLES / 2);
    localparam logic [TW-1:0] T_V2   = TW'(N_SAMPLES / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(N_SAMPLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(N_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    localparam parity_t PAR_MODE = parity_t'(PARITY);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_rx: CLOCK_RATE / (BAUD_RATE * N_SAMPLES) must be at least 2");
    end
    if (N_BITS < 5 || N_BITS > 9) begin : g_bad_nbits
        $error("uart_rx: N_BITS must be in 5..9");
    end
    if (N_SAMPLES < 4 || N_SAMPLES > 32) begin : g_bad_nsamples
        $error("uart_rx: N_SAMPLES must be in 4..32");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx: STOP_BITS must be 1 or 2");
    end

    // Synchronizer stages and edge detection
    logic        rx_p0_q;
    logic        rx_p1_q;
    logic        rx_s;
    logic [1:0]  flush_q;
    logic [1:0]  flush_d;
    logic        rx_prev_q;
    logic        rx_prev_d;
    logic        fall;

    // Frame state
    state_t            state_q,    state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_idx_q,  bit_idx_d;
    logic              vote0_q,    vote0_d;
    logic              vote1_q,    vote1_d;
    logic              bit_q,      bit_d;
    logic [N_BITS-1:0] shreg_q,    shreg_d;
    logic              perr_q,     perr_d;
    logic              ferr_q,     ferr_d;

    // Output registers
    logic [N_BITS-1:0] data_out_q,   data_out_d;
    logic              valid_q,      valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q,  frame_err_d;
    logic              overrun_q,    overrun_d;

    logic tick;
    logic tick_clr;
    logic maj_now;
    logic bit_now;
    logic ferr_next;
    logic par_exp;
    logic complete;

    baud_tick_gen #(
        .DIVISOR(DIVISOR)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    assign rx_s = rx_p1_q;

    always_comb begin
        // The synchronizer resets to 1, so the edge register is held at 0
        // until real line samples have flushed through; a line that is
        // already low after reset therefore never looks like a start edge.
        flush_d   = {flush_q[0], 1'b1};
        rx_prev_d = rx_s & flush_q[1];
        fall      = rx_prev_q & ~rx_s;

        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        vote0_d      = vote0_q;
        vote1_d      = vote1_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        valid_d      = valid_q;
        tick_clr     = 1'b0;
        complete     = 1'b0;
        ferr_next    = ferr_q;
        par_exp      = (^shreg_q) ^ (PAR_MODE == PAR_ODD);

        // Third vote is taken live so the decision is available on the
        // same tick; with small N_SAMPLES that tick is also the bit end.
        maj_now = maj3(vote0_q, vote1_q, rx_s);
        bit_now = (tick_cnt_q == T_V2) ? maj_now : bit_q;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (fall) begin
                state_d    = ST_START;
                tick_cnt_d = '0;
                tick_clr   = 1'b1;
                bit_idx_d  = '0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
            end
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == T_V0) vote0_d = rx_s;
            if (tick_cnt_q == T_V1) vote1_d = rx_s;
            if (tick_cnt_q == T_V2) bit_d = maj_now;

            case (state_q)
                ST_START: begin
                    if (tick_cnt_q == T_LAST) begin
                        bit_idx_d = '0;
                        state_d   = bit_now ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == T_LAST) begin
                        // Right shift: after N_BITS bits the first (LSB) bit
                        // lands in shreg[0].
                        shreg_d = {bit_now, shreg_q[N_BITS-1:1]};
                        if (bit_idx_q == B_LAST) begin
                            bit_idx_d = '0;
                            state_d   = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == T_LAST) begin
                        perr_d    = (bit_now != par_exp);
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == T_V2) begin
                        ferr_next = ferr_q | ~maj_now;
                        ferr_d    = ferr_next;
                        // Finish at the decision point of the last stop bit
                        // so the next start edge can be caught right away.
                        if (bit_idx_q == S_LAST) begin
                            complete   = 1'b1;
                            state_d    = ST_IDLE;
                            tick_cnt_d = '0;
                        end
                    end
                    if ((tick_cnt_q == T_LAST) && !complete) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (complete) begin
            if (!valid_q || ready) begin
                data_out_d   = shreg_q;
                parity_err_d = perr_q;
                frame_err_d  = ferr_next;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0_q      <= 1'b1;
            rx_p1_q      <= 1'b1;
            flush_q      <= '0;
            rx_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            vote0_q      <= 1'b0;
            vote1_q      <= 1'b0;
            bit_q        <= 1'b0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_p0_q      <= rx;
            rx_p1_q      <= rx_p0_q;
            flush_q      <= flush_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            vote0_q      <= vote0_d;
            vote1_q      <= vote1_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with three configurations:
//   dut_a - defaults (8N1), dut_p - even parity, dut_t - two stop bits.
// Bit period is 400 clocks (DIVISOR 25, 16 samples).
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_a, rx_p, rx_t;
    logic       ready_a, ready_p, ready_t;
    logic [7:0] data_out_a, data_out_p, data_out_t;
    logic       valid_a, valid_p, valid_t;
    logic       parity_err_a, parity_err_p, parity_err_t;
    logic       frame_err_a, frame_err_p, frame_err_t;
    logic       overrun_a, overrun_p, overrun_t;

    int total = 0;
    int bad   = 0;

    int         cap_cnt_a = 0, cap_cnt_p = 0, cap_cnt_t = 0;
    logic [7:0] cap_data_a = '0, cap_data_p = '0, cap_data_t = '0;
    logic       cap_perr_a = 1'b0, cap_perr_p = 1'b0;
    logic       cap_ferr_a = 1'b0, cap_ferr_t = 1'b0;
    int         ovr_cyc_a = 0;

    uart_rx #(.CLOCK_RATE(100000000), .BAUD_RATE(250000), .N_BITS(8),
              .N_SAMPLES(16), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(data_out_a), .valid(valid_a),
        .ready(ready_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
        .overrun(overrun_a));

    uart_rx #(.CLOCK_RATE(100000000), .BAUD_RATE(250000), .N_BITS(8),
              .N_SAMPLES(16), .PARITY(1), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .data_out(data_out_p), .valid(valid_p),
        .ready(ready_p), .parity_err(parity_err_p), .frame_err(frame_err_p),
        .overrun(overrun_p));

    uart_rx #(.CLOCK_RATE(100000000), .BAUD_RATE(250000), .N_BITS(8),
              .N_SAMPLES(16), .PARITY(0), .STOP_BITS(2)) dut_t (
        .clk(clk), .rst(rst), .rx(rx_t), .data_out(data_out_t), .valid(valid_t),
        .ready(ready_t), .parity_err(parity_err_t), .frame_err(frame_err_t),
        .overrun(overrun_t));

    // Record every accepted frame, sampled between clock edges.
    always @(negedge clk) begin
        #1;
        if (valid_a && ready_a) begin
            cap_cnt_a++;
            cap_data_a = data_out_a;
            cap_perr_a = parity_err_a;
            cap_ferr_a = frame_err_a;
        end
        if (overrun_a) ovr_cyc_a++;
        if (valid_p && ready_p) begin
            cap_cnt_p++;
            cap_data_p = data_out_p;
            cap_perr_p = parity_err_p;
        end
        if (valid_t && ready_t) begin
            cap_cnt_t++;
            cap_data_t = data_out_t;
            cap_ferr_t = frame_err_t;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_t = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends start, 8 data bits LSB first, optional parity bit and nstop stop
    // bits, each bitlen clocks long. rst_bit >= 0 pulses rst for one clock
    // halfway through that frame bit (0 = start bit).
    task automatic send_frame(input int which, input logic [7:0] data, input int use_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops,
                              input int bitlen, input int rst_bit);
        logic [15:0] frame;
        int n;
        frame    = '0;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1+i] = data[i];
        n = 9;
        if (use_par != 0) begin
            frame[n] = par_bit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            frame[n] = stops[i];
            n++;
        end
        for (int b = 0; b < n; b++) begin
            drive_rx(which, frame[b]);
            for (int c = 0; c < bitlen; c++) begin
                if (b == rst_bit && c == bitlen / 2) rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        drive_rx(which, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_t = 1'b1;
        ready_a = 1'b0; ready_p = 1'b0; ready_t = 1'b0;
        idle(5);
        rst = 1'b0;
        idle(2);

        // Reset state
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_out_a, 0);
        chk("rst_perr", parity_err_a, 0);
        chk("rst_ferr", frame_err_a, 0);
        chk("rst_ovr", overrun_a, 0);
        chk("rst_valid_p", valid_p, 0);

        // Nominal 0xA5 frame with ready held high
        ready_a = 1'b1; ready_p = 1'b1; ready_t = 1'b1;
        idle(20);
        send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11, 400, -1);
        idle(200);
        chk("a5_cnt", cap_cnt_a, 1);
        chk("a5_data", cap_data_a, 8'hA5);
        chk("a5_perr", cap_perr_a, 0);
        chk("a5_ferr", cap_ferr_a, 0);
        chk("a5_valid_low", valid_a, 0);
        chk("a5_ovr", ovr_cyc_a, 0);

        // Glitch: 100 clocks low is rejected as a false start
        drive_rx(0, 1'b0);
        idle(100);
        drive_rx(0, 1'b1);
        idle(600);
        chk("glitch_cnt", cap_cnt_a, 1);
        send_frame(0, 8'h3C, 0, 1'b0, 1, 2'b11, 400, -1);
        idle(200);
        chk("3c_cnt", cap_cnt_a, 2);
        chk("3c_data", cap_data_a, 8'h3C);
        chk("3c_ferr", cap_ferr_a, 0);

        // Even parity: 0x03 has two ones, so the correct parity bit is 0
        send_frame(1, 8'h03, 1, 1'b1, 1, 2'b11, 400, -1);
        idle(200);
        chk("par_bad_cnt", cap_cnt_p, 1);
        chk("par_bad_data", cap_data_p, 8'h03);
        chk("par_bad_perr", cap_perr_p, 1);
        send_frame(1, 8'h03, 1, 1'b0, 1, 2'b11, 400, -1);
        idle(200);
        chk("par_ok_cnt", cap_cnt_p, 2);
        chk("par_ok_data", cap_data_p, 8'h03);
        chk("par_ok_perr", cap_perr_p, 0);

        // Two stop bits: clean frame, second stop low, then a break
        send_frame(2, 8'h5A, 0, 1'b0, 2, 2'b11, 400, -1);
        idle(200);
        chk("stop_ok_cnt", cap_cnt_t, 1);
        chk("stop_ok_data", cap_data_t, 8'h5A);
        chk("stop_ok_ferr", cap_ferr_t, 0);
        send_frame(2, 8'h96, 0, 1'b0, 2, 2'b01, 400, -1);
        idle(200);
        chk("stop2_cnt", cap_cnt_t, 2);
        chk("stop2_data", cap_data_t, 8'h96);
        chk("stop2_ferr", cap_ferr_t, 1);
        send_frame(2, 8'h00, 0, 1'b0, 2, 2'b00, 400, -1);
        idle(200);
        chk("break_cnt", cap_cnt_t, 3);
        chk("break_data", cap_data_t, 8'h00);
        chk("break_ferr", cap_ferr_t, 1);

        // Overrun: 0x11 is held, back-to-back 0x22 is dropped
        ready_a = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1, 2'b11, 400, -1);
        send_frame(0, 8'h22, 0, 1'b0, 1, 2'b11, 400, -1);
        idle(100);
        chk("ovr_valid", valid_a, 1);
        chk("ovr_held_data", data_out_a, 8'h11);
        chk("ovr_pulse_cycles", ovr_cyc_a, 1);
        chk("ovr_no_capture", cap_cnt_a, 2);
        ready_a = 1'b1;
        idle(5);
        chk("ovr_drain_cnt", cap_cnt_a, 3);
        chk("ovr_drain_data", cap_data_a, 8'h11);
        chk("ovr_drain_valid", valid_a, 0);
        send_frame(0, 8'h33, 0, 1'b0, 1, 2'b11, 400, -1);
        idle(200);
        chk("33_cnt", cap_cnt_a, 4);
        chk("33_data", cap_data_a, 8'h33);
        chk("33_ovr", ovr_cyc_a, 1);

        // Reset mid data bit 4 (frame bit 5); 0xE0 keeps the line low there
        // and only rises afterwards, so no new start edge follows
        send_frame(0, 8'hE0, 0, 1'b0, 1, 2'b11, 400, 5);
        idle(800);
        chk("rst_mid_cnt", cap_cnt_a, 4);
        chk("rst_mid_valid", valid_a, 0);
        send_frame(0, 8'h5A, 0, 1'b0, 1, 2'b11, 400, -1);
        idle(200);
        chk("5a_cnt", cap_cnt_a, 5);
        chk("5a_data", cap_data_a, 8'h5A);
        chk("5a_ferr", cap_ferr_a, 0);

        // +/-3% baud mismatch
        send_frame(0, 8'h5A, 0, 1'b0, 1, 2'b11, 388, -1);
        idle(200);
        chk("fast_cnt", cap_cnt_a, 6);
        chk("fast_data", cap_data_a, 8'h5A);
        send_frame(0, 8'h5A, 0, 1'b0, 1, 2'b11, 412, -1);
        idle(200);
        chk("slow_cnt", cap_cnt_a, 7);
        chk("slow_data", cap_data_a, 8'h5A);
        chk("slow_ferr", cap_ferr_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised UART receiver; the successor to the first-generation bit-level receiver. It oversamples the asynchronous serial line and votes each bit by majority. It supports configurable data width, parity and stop-bit count, and delivers whole frames through a valid/ready handshake with per-frame error flags. It sits between the board RX pin and any byte-stream consumer, such as a command parser or FIFO.

## Interface
Parameters:
- CLOCK_RATE, 100000000: system clock frequency in Hz.
- BAUD_RATE, 250000: line rate in baud.
- N_BITS, 8: data bits per frame, legal range 5..9.
- N_SAMPLES, 16: oversampling ticks per bit, legal range 4..32.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- Derived: DIVISOR = CLOCK_RATE / (BAUD_RATE * N_SAMPLES), integer-truncated. Elaboration fails if DIVISOR < 2.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  N_BITS  received data, LSB first on the line.
- valid  out  1  data_out and the error flags hold a frame.
- ready  in  1  consumer accepts the frame when valid && ready.
- parity_err  out  1  parity mismatch for the held frame. Always 0 when PARITY = 0.
- frame_err  out  1  a stop bit was sampled 0 for the held frame.
- overrun  out  1  one-cycle pulse: a frame completed while valid was high and was dropped.

## Operation
- rx passes through a 2-flop synchronizer. All logic uses the synchronized signal rx_s.
- Tick generator:
  - Counts 0..DIVISOR-1 and emits `tick` on the wrap.
  - Free-running, except it is cleared to 0 when a start edge is detected in IDLE.
- Bit timing:
  - Each bit period is N_SAMPLES ticks, counted by tick_cnt from 0 to N_SAMPLES-1.
  - Bit value = majority of rx_s at tick_cnt = N_SAMPLES/2-1, N_SAMPLES/2 and N_SAMPLES/2+1.
- States (enum state_t): IDLE, START, DATA, PARITY, STOP.
  - IDLE: falling edge on rx_s (previous 1, now 0) → START. tick_cnt = 0, tick generator cleared.
  - START: at tick_cnt = N_SAMPLES-1:
    - If the voted start bit is 0 → DATA, bit_idx = 0.
    - Otherwise (false start/glitch) → IDLE, with no output.
  - DATA: shift the voted bit into shreg[bit_idx] at the end of each bit period.
    - After bit N_BITS-1 → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample the voted bit and compare with the XOR of the data (even), or its inverse (odd). Then → STOP.
  - STOP: at the majority-decision point of each stop bit, a voted 0 sets the frame_err latch.
    - At the decision point of the last stop bit (tick_cnt = N_SAMPLES/2+1) the frame completes. State → IDLE immediately, with no wait for the bit end, to allow resync on back-to-back frames.
- Frame completion:
  - If valid = 0 or the handshake completes that cycle: load data_out, parity_err and frame_err; valid = 1 next cycle.
  - Else: pulse overrun for 1 cycle. Keep the held frame unchanged and drop the new one.
- Errored frames are still delivered, with their flags set. A break (all zeros) yields frame_err = 1 and data_out = 0.
- Handshake: valid stays high until the cycle with valid && ready. It deasserts in the following cycle unless a new frame completes in that same handshake cycle.

## Timing
- Reset values: valid = 0, data_out = 0, parity_err = 0, frame_err = 0, overrun = 0, state IDLE, all counters 0, synchronizer flops = 1.
- rst asserted mid-frame aborts the frame with no output. After release, the receiver waits for a fresh falling edge; a line already low is not treated as a start.
- Latency: valid rises 1 clk after the tick that samples the last stop bit's third vote, i.e. (N_SAMPLES/2+1) ticks into the last stop bit.
- Input-to-detection delay: 2 clk (synchronizer) + 1 clk (edge register).
- A new frame and a handshake in the same cycle are legal. No overrun occurs and the new frame is loaded.
- Counter widths: $clog2(DIVISOR), $clog2(N_SAMPLES), $clog2(N_BITS+1). All compare with == against the terminal value. No wrap beyond the terminal value.

## Structure
- Package uart_pkg:
  - state_t enum.
  - parity_t enum: PAR_NONE, PAR_EVEN, PAR_ODD.
  - function maj3.
- One sub-module, baud_tick_gen (parameter DIVISOR). Ports: clk, rst, clr, tick. Shared with the planned uart_tx.

## Test plan
Defaults apply unless stated: DIVISOR = 25, bit period = 400 clk.
- Nominal frame, ready held 1: frame 0xA5, no parity, 1 stop → one valid pulse, data_out = 0xA5, all error flags 0.
- Glitch: rx low for 100 clk, then high → no valid, state back to IDLE. A following 0x3C frame is received correctly.
- Parity error: PARITY = 1 (even), frame 0x03 with parity bit 1 → valid with data_out = 0x03, parity_err = 1. Same frame with parity bit 0 → parity_err = 0.
- Framing error: STOP_BITS = 2, second stop bit driven 0 → frame_err = 1, data intact. A break of all zeros → data_out = 0x00, frame_err = 1.
- Overrun: ready = 0, frames 0x11 then 0x22 back-to-back → data_out stays 0x11, overrun pulses 1 clk at 0x22 completion. Raise ready, then send 0x33 → delivered normally.
- Reset: rst for 1 clk in the middle of data bit 4 → no valid. The next frame 0x5A is received cleanly. Also check a ±3% baud mismatch still decodes 0x5A.
